// File: rtl/sensors_scan.sv
// -----------------------------------------------------------------------------
// sensors_scan
// Sequential acquisition front-end. Polls nr_sensors sensors one at a time over
// a request/acknowledge handshake, collects one 8-bit reading per sensor, marks
// sensors that stay silent for timeout_cycles as disabled, and publishes a
// consistent snapshot at the end of each round.
//
// Parameters:
//   nr_sensors      sensors per round (1..200)
//   timeout_cycles  unanswered request cycles before a sensor is absent (1..255)
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             synchronous active-high reset
//   start_i           start one round (sampled in IDLE only)
//   sensor_addr_o     index of the sensor being polled
//   sensor_req_o      request to the addressed sensor
//   sensor_ack_i      sensor response strobe (sampled in REQ only)
//   sensor_data_i     reading, valid with sensor_ack_i
//   sensors_data_o    published readings, sensor k at [8k+7:8k]
//   sensors_en_o      published per-sensor enable
//   snapshot_valid_o  one-cycle pulse with each new snapshot
//   busy_o            round in progress
// -----------------------------------------------------------------------------
module sensors_scan #(
   parameter int unsigned nr_sensors     = 200,
   parameter int unsigned timeout_cycles = 15
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   output logic [7:0]                sensor_addr_o,
   output logic                      sensor_req_o,
   input  logic                      sensor_ack_i,
   input  logic [7:0]                sensor_data_i,
   output logic [8*nr_sensors-1:0]   sensors_data_o,
   output logic [nr_sensors-1:0]     sensors_en_o,
   output logic                      snapshot_valid_o,
   output logic                      busy_o
);

   localparam int unsigned IW        = (nr_sensors > 1) ? $clog2(nr_sensors) : 1;
   localparam logic [7:0]  LAST_ADDR = 8'(nr_sensors - 1);
   localparam logic [7:0]  TMR_LAST  = 8'(timeout_cycles - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_NEXT,
      S_PUBLISH
   } state_t;

   state_t                    r_state;
   logic [7:0]                r_addr;
   logic [7:0]                r_timer;
   logic                      r_req;
   logic                      r_busy;
   logic                      r_valid;
   logic [7:0]                r_work_data [nr_sensors];
   logic [nr_sensors-1:0]     r_work_en;
   logic [8*nr_sensors-1:0]   r_pub_data;
   logic [nr_sensors-1:0]     r_pub_en;

   logic [IW-1:0]             w_idx;

   // Address never exceeds nr_sensors-1, so the low bits index the slot arrays.
   assign w_idx = r_addr[IW-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_timer    <= '0;
         r_req      <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_work_en  <= '0;
         r_pub_data <= '0;
         r_pub_en   <= '0;
         for (int unsigned i = 0; i < nr_sensors; i++) begin
            r_work_data[i] <= '0;
         end
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_timer <= '0;
                  r_addr  <= '0;
                  r_req   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_REQ;
               end
            end

            S_REQ: begin
               // An ack in the expiry cycle takes priority over the timeout.
               if (sensor_ack_i) begin
                  r_work_data[w_idx] <= sensor_data_i;
                  r_work_en[w_idx]   <= 1'b1;
                  r_req              <= 1'b0;
                  r_state            <= S_NEXT;
               end else if (r_timer == TMR_LAST) begin
                  r_work_data[w_idx] <= '0;
                  r_work_en[w_idx]   <= 1'b0;
                  r_req              <= 1'b0;
                  r_state            <= S_NEXT;
               end else begin
                  r_timer <= r_timer + 8'd1;
               end
            end

            S_NEXT: begin
               r_timer <= '0;
               if (r_addr == LAST_ADDR) begin
                  r_state <= S_PUBLISH;
               end else begin
                  r_addr  <= r_addr + 8'd1;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end

            S_PUBLISH: begin
               for (int unsigned i = 0; i < nr_sensors; i++) begin
                  r_pub_data[8*i +: 8] <= r_work_data[i];
               end
               r_pub_en <= r_work_en;
               r_valid  <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign sensor_addr_o    = r_addr;
   assign sensor_req_o     = r_req;
   assign sensors_data_o   = r_pub_data;
   assign sensors_en_o     = r_pub_en;
   assign snapshot_valid_o = r_valid;
   assign busy_o           = r_busy;

endmodule

// File: doc/sensors_scan.md
# sensors_scan

Sequential acquisition front-end for the temperature-monitoring datapath. It polls up to `nr_sensors` sensors one at a time over a request/acknowledge handshake, collects one 8-bit reading per sensor, and marks silent sensors as disabled after a timeout. At the end of each round it publishes a consistent snapshot, `sensors_data_o` and `sensors_en_o`, which connects directly to the `sensors_data_i` / `sensors_en_i` inputs of `temperature_top`.

## Interface
- `nr_sensors`, default 200: sensors per round; legal range 1..200.
- `timeout_cycles`, default 15: cycles of unanswered request before a sensor is declared absent; legal range 1..255.

Ports:
- `clk_i` input 1: single clock; all logic on rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `start_i` input 1: starts one scan round when sampled high in IDLE.
- `sensor_addr_o` output 8: index of the sensor being polled.
- `sensor_req_o` output 1: request to the addressed sensor.
- `sensor_ack_i` input 1: sensor response strobe.
- `sensor_data_i` input 8: reading, valid when `sensor_ack_i`=1.
- `sensors_data_o` output 8*nr_sensors: published readings; sensor k occupies bits [8k+7:8k].
- `sensors_en_o` output nr_sensors: published enable per sensor.
- `snapshot_valid_o` output 1: one-cycle pulse when a new snapshot is published.
- `busy_o` output 1: round in progress.

## Operation
- States: IDLE, REQ, NEXT, PUBLISH.
- **IDLE**: `sensor_req_o`=0 and `busy_o`=0. If `start_i`=1, clear the timer, set addr=0, and go to REQ.
- **REQ**: `sensor_req_o`=1 and `sensor_addr_o`=addr.
  - If `sensor_ack_i`=1: store `sensor_data_i` in working slot addr, set working en[addr]=1, and go to NEXT.
  - Else if the timer equals `timeout_cycles`-1: store 0 in slot addr, set en[addr]=0, and go to NEXT.
  - Otherwise the timer increments.
  - An ack in the expiry cycle wins: the reading is captured and en=1.
- **NEXT**: `sensor_req_o`=0, giving a one-cycle return-to-zero between sensors. The timer clears.
  - If addr==`nr_sensors`-1, go to PUBLISH.
  - Else increment addr and go to REQ.
- **PUBLISH**: copy the working arrays into the `sensors_data_o` / `sensors_en_o` registers and go to IDLE.
- Published outputs change only at PUBLISH. Downstream never sees a partially updated round.
- `busy_o`=1 in REQ, NEXT and PUBLISH.
- Ignored inputs:
  - `start_i` outside IDLE.
  - `sensor_ack_i` outside REQ.
- Widths:
  - Address counter is 8 bits and never exceeds `nr_sensors`-1; no wrap.
  - Timer is 8 bits.
- Reset, including mid-round, forces every value below to 0 and discards the working data:
  - state goes to IDLE
  - addr, timer
  - `sensor_req_o`, `sensor_addr_o`
  - `busy_o`, `snapshot_valid_o`
  - `sensors_data_o`, `sensors_en_o`
- Consequence: after reset, downstream sees zero active sensors.

## Timing
- Let E0 be the edge at which `start_i` is sampled in IDLE.
- `sensor_req_o` rises in the cycle after E0, with `sensor_addr_o`=0.
- Immediate ack (ack in the first REQ cycle): 2 cycles per sensor (REQ + NEXT).
- Timeout: REQ lasts exactly `timeout_cycles` cycles, then 1 NEXT cycle.
- Outputs load on the edge leaving PUBLISH. `snapshot_valid_o` is registered and is high for exactly the one cycle after that edge, with the new data visible in that same cycle.
- Full round with all sensors acking immediately: `snapshot_valid_o` is high in cycle 2·`nr_sensors`+2 after E0, and `busy_o` is low in that cycle.
- A `start_i` held high restarts on the edge after PUBLISH. Back-to-back rounds have no dead cycle beyond IDLE.
- Slot and output writes are registered; no combinational path from `sensor_ack_i` to any output.

## Test plan
Bench uses `nr_sensors`=4 and `timeout_cycles`=3 unless noted.
- **All sensors ack immediately.** Data 0x10, 0x20, 0x30, 0x40 → `sensors_data_o`=0x40302010, `sensors_en_o`=4'b1111, `snapshot_valid_o` high once in cycle 10 after E0.
- **Sensor 2 never acks, others ack 0x19.** → `sensors_en_o`=4'b1011 and data slot 2 = 0x00. REQ for addr 2 lasts exactly 3 cycles; valid pulse in cycle 12.
- **Ack in the final timeout cycle.** Sensor 1 acks 0x55 in its third REQ cycle → en[1]=1, slot 1 = 0x55. A stray ack in the following NEXT cycle is ignored.
- **Start while busy, and published-output stability.** `start_i` pulses during round 1 → no effect. Round 2 with new data: `sensors_data_o` holds round-1 values until round 2's PUBLISH edge.
- **Reset mid-round.** `rst_i` asserted at addr 2 → next cycle all outputs are 0. A new `start_i` begins at addr 0, and the completed snapshot contains no pre-reset data.
- **Full-size integration.** `nr_sensors`=200 feeding `temperature_top`, all ack 0x19 → valid in cycle 402, and `temperature_top` computes its average over 200 active sensors.
